// File: rtl/mem_if_pipe.sv
// mem_if_pipe: single-port synchronous word memory behind a request/response
// interface. It supports byte-write strobes, a fixed response latency, a flag
// for out-of-range addresses, and an optional clear sweep after reset.
//
// Handshake: a request is accepted at a rising edge where req_i=1 and
// req_ready_o=1. At most one request is accepted per cycle. Every accepted
// request gets exactly one response. Responses come out in order, RD_LAT
// cycles after acceptance, as a one-cycle rsp_valid_o pulse. The requester
// cannot stall responses. When rsp_valid_o=0, rsp_rdata_o and rsp_err_o
// are held at 0.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   req_i        request valid
//   req_rnw_i    1 = read, 0 = write
//   req_addr_i   word address
//   req_wdata_i  write data
//   req_be_i     byte enables, bit k covers wdata[8k+7:8k]
//   req_ready_o  request can be accepted this cycle
//   rsp_valid_o  response valid pulse
//   rsp_rdata_o  read data (0 for writes and errors)
//   rsp_err_o    address >= DEPTH, qualified by rsp_valid_o
//   dbg_state_o  FSM state (0 = INIT sweep, 1 = READY)
module mem_if_pipe #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int DEPTH      = 16,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic                req_rnw_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_be_i,
    output logic                req_ready_o,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                dbg_state_o
);

    localparam int BE_W = DATA_W / 8;
    // DEPTH is held one bit wider than the address, so DEPTH = 2**ADDR_W fits.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $error("mem_if_pipe: DATA_W must be a positive multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("mem_if_pipe: DEPTH must be in 1..2**ADDR_W");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("mem_if_pipe: RD_LAT must be in 1..4");
    end

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                clr_we;
    logic                acc;
    logic                in_range;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic [RD_LAT-1:0]   vld_q;
    logic [RD_LAT-1:0]   err_q;
    logic [DATA_W-1:0]   dat_q [RD_LAT];

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (INIT_CLEAR != 0) ? ST_INIT : ST_READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clr_we      = 1'b0;
        req_ready_o = 1'b0;
        case (state_q)
            ST_INIT: begin
                // One word is cleared per cycle. The sweep leaves INIT on the
                // same edge that writes the last word.
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if ({1'b0, cnt_q} == DEPTH_L - 1'b1) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                req_ready_o = 1'b1;
            end
            default: begin
                state_d = ST_READY;
            end
        endcase
    end

    assign dbg_state_o = state_q;
    assign acc         = req_i & req_ready_o;
    assign in_range    = ({1'b0, req_addr_i} < DEPTH_L);

    // ---------------- storage ----------------
    // rst does not reset the storage. Only the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[cnt_q] <= '0;
            end else if (acc && !req_rnw_i && in_range) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (req_be_i[b]) begin
                        mem[req_addr_i][8*b +: 8] <= req_wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

    // ---------------- response pipeline ----------------
    // Stage 0 captures the response at the accepting edge. The last stage
    // drives the outputs. Any stage not carrying a response holds zero data,
    // so the output is zero whenever valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= acc;
            err_q[0] <= acc & ~in_range;
            dat_q[0] <= (acc && req_rnw_i && in_range) ? mem[req_addr_i] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign rsp_valid_o = vld_q[RD_LAT-1];
    assign rsp_err_o   = err_q[RD_LAT-1];
    assign rsp_rdata_o = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_mem_if_pipe.sv
// Directed bench for mem_if_pipe. Four instances share one request bus. Each
// instance has its own request-valid bit, and only one instance is driven
// at a time:
//   0: DEPTH=16 RD_LAT=1 INIT_CLEAR=1
//   1: DEPTH=13 RD_LAT=1 INIT_CLEAR=1
//   2: DEPTH=16 RD_LAT=3 INIT_CLEAR=1
//   3: DEPTH=16 RD_LAT=2 INIT_CLEAR=0
module tb_mem_if_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic [3:0]  req_v;
  logic        rnw;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [3:0]  ready;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_err;
  logic [3:0]  dbg;
  logic [31:0] rsp_rdata [4];

  int lat_of [4] = '{1, 1, 3, 2};

  mem_if_pipe #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(1), .INIT_CLEAR(1)) u_a (
    .clk(clk), .rst(rst), .req_i(req_v[0]), .req_rnw_i(rnw), .req_addr_i(addr),
    .req_wdata_i(wdata), .req_be_i(be), .req_ready_o(ready[0]), .rsp_valid_o(rsp_valid[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]), .dbg_state_o(dbg[0]));

  mem_if_pipe #(.DATA_W(32), .ADDR_W(4), .DEPTH(13), .RD_LAT(1), .INIT_CLEAR(1)) u_b (
    .clk(clk), .rst(rst), .req_i(req_v[1]), .req_rnw_i(rnw), .req_addr_i(addr),
    .req_wdata_i(wdata), .req_be_i(be), .req_ready_o(ready[1]), .rsp_valid_o(rsp_valid[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]), .dbg_state_o(dbg[1]));

  mem_if_pipe #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(3), .INIT_CLEAR(1)) u_c (
    .clk(clk), .rst(rst), .req_i(req_v[2]), .req_rnw_i(rnw), .req_addr_i(addr),
    .req_wdata_i(wdata), .req_be_i(be), .req_ready_o(ready[2]), .rsp_valid_o(rsp_valid[2]),
    .rsp_rdata_o(rsp_rdata[2]), .rsp_err_o(rsp_err[2]), .dbg_state_o(dbg[2]));

  mem_if_pipe #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_LAT(2), .INIT_CLEAR(0)) u_d (
    .clk(clk), .rst(rst), .req_i(req_v[3]), .req_rnw_i(rnw), .req_addr_i(addr),
    .req_wdata_i(wdata), .req_be_i(be), .req_ready_o(ready[3]), .rsp_valid_o(rsp_valid[3]),
    .rsp_rdata_o(rsp_rdata[3]), .rsp_err_o(rsp_err[3]), .dbg_state_o(dbg[3]));

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Every response must match the oldest expectation for its instance and
  // must arrive in the expected cycle. Idle outputs must be zero.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      for (int i = 0; i < 4; i++) begin
        if (rsp_valid[i]) begin
          if (exp_q.size() > 0 && exp_q[0].id == 2'(i)) begin
            e = exp_q.pop_front();
            check("rsp_data", 64'(rsp_rdata[i]), 64'(e.data));
            check("rsp_err", 64'(rsp_err[i]), 64'(e.err));
            check("rsp_cycle", 64'(cyc), 64'(e.due));
          end else begin
            check("unexpected_rsp", 64'(i + 1), 64'd0);
          end
        end else begin
          check("idle_zero", {31'b0, rsp_err[i], rsp_rdata[i]}, 64'd0);
        end
      end
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        check("missing_rsp", 64'(e.due), 64'(cyc));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge. Drives one request for one cycle and records the
  // expected response.
  task automatic issue(input int sel, input logic r, input logic [3:0] a,
                       input logic [31:0] wd, input logic [3:0] b,
                       input logic [31:0] ed, input logic ee);
    exp_t e;
    check("ready_at_issue", 64'(ready[sel]), 64'd1);
    req_v      = '0;
    req_v[sel] = 1'b1;
    rnw        = r;
    addr       = a;
    wdata      = wd;
    be         = b;
    e.id       = 2'(sel);
    e.data     = ed;
    e.err      = ee;
    e.due      = cyc + lat_of[sel];
    exp_q.push_back(e);
    @(negedge clk);
    req_v = '0;
  endtask

  // One-cycle reset. For the first cycles of the sweep, a write to word 5
  // is held on the sweeping instances. These requests must be ignored. The
  // task then counts the not-ready cycles of each instance.
  task automatic do_reset();
    int nr [4];
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    nr  = '{default: 0};
    for (int c = 0; c < 40; c++) begin
      if (c < 5) begin
        req_v = 4'b0111; rnw = 1'b0; addr = 4'h5; wdata = 32'hFFFF_FFFF; be = 4'hF;
      end else begin
        req_v = '0;
      end
      for (int i = 0; i < 4; i++) if (!ready[i]) nr[i]++;
      @(negedge clk);
    end
    req_v = '0;
    check("init_len_a", 64'(nr[0]), 64'd16);
    check("init_len_b", 64'(nr[1]), 64'd13);
    check("init_len_c", 64'(nr[2]), 64'd16);
    check("init_len_d", 64'(nr[3]), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    req_v = '0; rnw = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    do_reset();

    // Clear sweep: a word written before reset reads back as zero afterwards.
    issue(0, 1'b0, 4'h5, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b1, 4'h5, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
    repeat (4) @(negedge clk);
    do_reset();
    issue(0, 1'b1, 4'h5, 32'h0, 4'h0, 32'h0, 1'b0);

    // Write followed immediately by a read of the same word.
    issue(0, 1'b0, 4'h4, 32'h9215_3524, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b1, 4'h4, 32'h0, 4'h0, 32'h9215_3524, 1'b0);

    // Byte enables, including an all-zero strobe.
    issue(0, 1'b0, 4'h3, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    issue(0, 1'b0, 4'h3, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0);
    issue(0, 1'b1, 4'h3, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
    issue(0, 1'b0, 4'h3, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0);
    issue(0, 1'b1, 4'h3, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0);
    repeat (4) @(negedge clk);

    // DEPTH=13: addresses 13..15 are errors and must not alias onto real words.
    issue(1, 1'b0, 4'hC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    issue(1, 1'b0, 4'hE, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
    issue(1, 1'b1, 4'hE, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(1, 1'b1, 4'hD, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(1, 1'b1, 4'hF, 32'h0, 4'h0, 32'h0, 1'b1);
    issue(1, 1'b1, 4'hC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);
    issue(1, 1'b1, 4'h1, 32'h0, 4'h0, 32'h0, 1'b0);
    issue(1, 1'b1, 4'h6, 32'h0, 4'h0, 32'h0, 1'b0);
    repeat (4) @(negedge clk);

    // RD_LAT=3: back-to-back writes, then ten back-to-back reads.
    for (int i = 0; i < 10; i++)
      issue(2, 1'b0, 4'(i), 32'h1000_0000 + 32'(i) * 32'h111, 4'hF, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++)
      issue(2, 1'b1, 4'(i), 32'h0, 4'h0, 32'h1000_0000 + 32'(i) * 32'h111, 1'b0);
    repeat (6) @(negedge clk);

    // RD_LAT=2 with no clear sweep.
    issue(3, 1'b0, 4'h7, 32'h0BAD_C0DE, 4'hF, 32'h0, 1'b0);
    issue(3, 1'b1, 4'h7, 32'h0, 4'h0, 32'h0BAD_C0DE, 1'b0);
    repeat (4) @(negedge clk);

    // Reset while two reads are in flight. The flushed expectations make any
    // late response show up as unexpected.
    issue(2, 1'b1, 4'h0, 32'h0, 4'h0, 32'h1000_0000, 1'b0);
    issue(2, 1'b1, 4'h1, 32'h0, 4'h0, 32'h1000_0111, 1'b0);
    do_reset();
    issue(2, 1'b1, 4'h9, 32'h0, 4'h0, 32'h0, 1'b0);
    issue(3, 1'b1, 4'h7, 32'h0, 4'h0, 32'h0BAD_C0DE, 1'b0);
    repeat (6) @(negedge clk);

    check("drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
